// File: rtl/prime_seq_gen.sv
// Streams primes in ascending order over a valid/ready handshake using iterative trial division.
// Optional PRIME_COUNT_EN adds a prime_count output counting accepted transfers.
module prime_seq_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_from,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             busy,
  output logic             done,
  output logic             wrapped
`ifdef PRIME_COUNT_EN
  ,
  output logic [WIDTH-1:0] prime_count
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_TST  = 3'd3;
  localparam logic [2:0] S_DIVD = 3'd4;
  localparam logic [2:0] S_EMIT = 3'd5;
  localparam logic [2:0] S_NEXT = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CMAX     = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0] THREE    = WIDTH'(3);

  logic [2:0]       state;
  logic [WIDTH-1:0] cand, div, sf_q, dvd, rem, rem_nx;
  logic             wrap_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rsh;
  logic [2*WIDTH-1:0] sq;
  logic             sq_gt;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rsh    = {rem, dvd[WIDTH-1]};
    rem_nx = rsh[WIDTH-1:0];
    if (rsh >= {1'b0, div}) rem_nx = WIDTH'(rsh - {1'b0, div});
    sq     = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
    sq_gt  = sq > {{WIDTH{1'b0}}, cand};
  end

  assign prime_valid = (state == S_EMIT);
  assign prime_out   = prime_valid ? cand : '0;
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cand    <= '0;
      div     <= '0;
      sf_q    <= '0;
      dvd     <= '0;
      rem     <= '0;
      cnt     <= '0;
      wrap_q  <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          sf_q   <= start_from;
          wrap_q <= wrap_en;
          state  <= S_LOAD;
        end
        S_LOAD: begin
          cand  <= (sf_q < TWO) ? TWO : sf_q;
          state <= S_CHK;
        end
        S_CHK: begin
          if (cand == TWO || cand == THREE) state <= S_EMIT;
          else if (!cand[0])                state <= S_NEXT;
          else begin
            div   <= THREE;
            state <= S_TST;
          end
        end
        S_TST: begin
          if (sq_gt) state <= S_EMIT;
          else begin
            rem   <= '0;
            dvd   <= cand;
            cnt   <= '0;
            state <= S_DIVD;
          end
        end
        S_DIVD: begin
          rem <= rem_nx;
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            if (rem_nx == '0) state <= S_NEXT;
            else begin
              div   <= div + TWO;
              state <= S_TST;
            end
          end
        end
        S_EMIT: if (prime_ready) state <= S_NEXT;
        S_NEXT: begin
          // Top-of-range test happens before the increment so cand never overflows.
          if (cand == CMAX) begin
            if (wrap_q) begin
              cand    <= TWO;
              wrapped <= 1'b1;
              state   <= S_CHK;
            end else state <= S_DONE;
          end else begin
            cand  <= cand + ONE;
            state <= S_CHK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PRIME_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             prime_count <= '0;
    else if (start && (state == S_IDLE || state == S_DONE)) prime_count <= '0;
    else if (prime_valid && prime_ready)                    prime_count <= prime_count + ONE;
  end
`endif

endmodule

// File: tb/tb_prime_seq_gen.sv
// Scoreboard bench for prime_seq_gen: stimulus pushes expected primes, a negedge monitor pops on transfers.
module tb_prime_seq_gen;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] start_from = '0;
  logic         wrap_en = 1'b0;
  logic [W-1:0] prime_out;
  logic         prime_valid;
  logic         prime_ready = 1'b0;
  logic         busy, done, wrapped;
`ifdef PRIME_COUNT_EN
  logic [W-1:0] prime_count;
`endif

  prime_seq_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_from(start_from), .wrap_en(wrap_en),
    .prime_out(prime_out), .prime_valid(prime_valid), .prime_ready(prime_ready),
    .busy(busy), .done(done), .wrapped(wrapped)
`ifdef PRIME_COUNT_EN
    , .prime_count(prime_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  int q[$];

  int primes[54] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61,
                     67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137,
                     139, 149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211,
                     223, 227, 229, 233, 239, 241, 251};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid&&ready seen at the negedge is one transfer at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wrapped) wrap_cnt++;
      if (prime_valid && prime_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_prime: got %0d expected none", prime_out);
        end else begin
          int e;
          e = q.pop_front();
          if (int'(prime_out) != e) begin
            errors++;
            $display("FAIL prime_seq: got %0d expected %0d", prime_out, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    start = 1'b0;
    prime_ready = 1'b0;
    #1;
    check("rst_out", int'(prime_out), 0);
    check("rst_valid", int'(prime_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wrapped", int'(wrapped), 0);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input int sf, input logic wr);
    start_from = W'(sf);
    wrap_en = wr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait until every expected prime has been transferred, then stall the consumer.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, q.size(), 0);
    q.delete();
    prime_ready = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(done), 1);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    bit stable;
    do_reset();

    // T1: full range from 0, stop at the top
    prime_ready = 1'b1;
    foreach (primes[i]) q.push_back(primes[i]);
    pulse_start(0, 1'b0);
    wait_done("t1_done", 30000);
    check("t1_queue", q.size(), 0);
`ifdef PRIME_COUNT_EN
    check("t1_count", int'(prime_count), 54);
`endif

    // T6b: start from DONE restarts from the new start_from
    q.push_back(251);
    pulse_start(250, 1'b0);
    wait_done("t6b_done", 2000);
    check("t6b_queue", q.size(), 0);
`ifdef PRIME_COUNT_EN
    check("t6b_count", int'(prime_count), 1);
`endif
    q.delete();

    // T2: wrap from the top back to 2
    do_reset();
    wrap_cnt = 0;
    prime_ready = 1'b1;
    q.push_back(251); q.push_back(2); q.push_back(3); q.push_back(5);
    pulse_start(250, 1'b1);
    drain("t2_drain", 2000);
    check("t2_wraps", wrap_cnt, 1);

    // T3: back-pressure holds 13, then 17 follows
    do_reset();
    q.push_back(13); q.push_back(17);
    pulse_start(12, 1'b0);
    n = 0;
    while (!prime_valid && n < 500) begin tick(); n++; end
    check("t3_valid", int'(prime_valid), 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!prime_valid || prime_out != W'(13)) stable = 1'b0;
    end
    check("t3_hold13", int'(stable), 1);
    prime_ready = 1'b1;
    drain("t3_drain", 2000);

    // T4: 24..28 composite; latency = LOAD + 2+20+2+11+2 + 20 states to EMIT, seen after edge 59
    do_reset();
    prime_ready = 1'b1;
    q.push_back(29);
    start_from = W'(24);
    wrap_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!prime_valid && n < 500) begin tick(); n++; end
    check("t4_latency", n, 59);
    drain("t4_drain", 200);

    // T5: reset during DIVD of 97 drops it; restart from 0 yields 2
    do_reset();
    prime_ready = 1'b1;
    pulse_start(97, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_out", int'(prime_out), 0);
    check("t5_valid", int'(prime_valid), 0);
    check("t5_busy0", int'(busy), 0);
    check("t5_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    q.push_back(2);
    pulse_start(0, 1'b0);
    drain("t5_drain", 200);

    // T6a: start while busy is ignored
    do_reset();
    prime_ready = 1'b1;
    q.push_back(2); q.push_back(3); q.push_back(5); q.push_back(7); q.push_back(11);
    pulse_start(0, 1'b0);
    tick(); tick(); tick();
    pulse_start(100, 1'b1);
    drain("t6a_drain", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
